// File: rtl/game_pkg.sv
// Shared state encoding, screen defaults and score helper for the game supervisor.
// Defining GAME_CTRL_INVULN_EN adds the ST_HIT post-hit invulnerability state.
package game_pkg;

    localparam int         XSCREEN_DEFAULT  = 640;
    localparam int         YSCREEN_DEFAULT  = 480;
    localparam logic [8:0] BG_COLOR_DEFAULT = 9'b111_111_111;
    localparam int         SCORE_MAX        = 9999;

    typedef enum logic [2:0] {
        ST_CLEAR      = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_PLAY       = 3'd2,
        ST_OVER       = 3'd3
`ifdef GAME_CTRL_INVULN_EN
        , ST_HIT      = 3'd4
`endif
    } state_e;

    function automatic logic [13:0] score_inc(input logic [13:0] s);
        return (s >= 14'(SCORE_MAX)) ? s : s + 14'd1;
    endfunction

endpackage

// File: rtl/screen_sweep.sv
// Raster address generator for the background clear: x inner, y outer.
// Counters sit at (0,0) whenever go is low, so every sweep starts at the origin.
module screen_sweep
    import game_pkg::*;
#(
    parameter int XSCREEN = XSCREEN_DEFAULT,
    parameter int YSCREEN = YSCREEN_DEFAULT
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       go,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active,
    output logic       done
);

    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       last_x, last_y;

    assign last_x = (x_q == 10'(XSCREEN - 1));
    assign last_y = (y_q == 9'(YSCREEN - 1));

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (go && !(last_x && last_y)) begin
            if (last_x) begin
                y_d = y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
                y_d = y_q;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign active = go;
    assign done   = go && last_x && last_y;

endmodule

// File: rtl/game_ctrl.sv
// Game supervisor: screen clear, lives/score tracking, obstacle-engine gating, VGA write mux.
// Define GAME_CTRL_INVULN_EN to enable the post-hit invulnerability (HIT) state.
module game_ctrl
    import game_pkg::*;
#(
    parameter int         XSCREEN       = XSCREEN_DEFAULT,
    parameter int         YSCREEN       = YSCREEN_DEFAULT,
    parameter int         LIVES         = 3,
    parameter int         SCORE_TICK    = 50_000_000,
    parameter int         INVULN_CYCLES = 50_000_000,
    parameter logic [8:0] BG_COLOR      = BG_COLOR_DEFAULT
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic        collision,
    input  logic [9:0]  obs_x,
    input  logic [8:0]  obs_y,
    input  logic [8:0]  obs_color,
    input  logic        obs_write,
    output logic [9:0]  VGA_x,
    output logic [8:0]  VGA_y,
    output logic [8:0]  VGA_color,
    output logic        VGA_write,
    output logic        obs_resetn,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic        game_over
);

    localparam int TICK_W = $clog2(SCORE_TICK + 1);

    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("game_ctrl: LIVES must be in 1..3");
    end
    if (SCORE_TICK < 1 || INVULN_CYCLES < 1) begin : g_bad_timing
        $error("game_ctrl: SCORE_TICK and INVULN_CYCLES must be positive");
    end

    state_e              state_q, state_d;
    logic                start_q, collision_q;
    logic                start_rise, hit_rise, alive;
    logic [1:0]          lives_q, lives_d;
    logic [13:0]         score_q, score_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                obs_resetn_q;
    logic [9:0]          vga_x_q, vga_x_d;
    logic [8:0]          vga_y_q, vga_y_d;
    logic [8:0]          vga_color_q, vga_color_d;
    logic                vga_write_q, vga_write_d;
    logic                sweep_go, sweep_active, sweep_done;
    logic [9:0]          sweep_x;
    logic [8:0]          sweep_y;
`ifdef GAME_CTRL_INVULN_EN
    localparam int INV_W = $clog2(INVULN_CYCLES + 1);
    logic [INV_W-1:0]    inv_q, inv_d;
`endif

    screen_sweep #(
        .XSCREEN (XSCREEN),
        .YSCREEN (YSCREEN)
    ) u_sweep (
        .Clock  (Clock),
        .Resetn (Resetn),
        .go     (sweep_go),
        .x      (sweep_x),
        .y      (sweep_y),
        .active (sweep_active),
        .done   (sweep_done)
    );

    assign start_rise = start && !start_q;
    assign hit_rise   = collision && !collision_q;
`ifdef GAME_CTRL_INVULN_EN
    assign alive = (state_q == ST_PLAY) || (state_q == ST_HIT);
`else
    assign alive = (state_q == ST_PLAY);
`endif

    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        tick_d      = '0;
        sweep_go    = 1'b0;
        vga_x_d     = obs_x;
        vga_y_d     = obs_y;
        vga_color_d = obs_color;
        vga_write_d = obs_write && obs_resetn_q;
`ifdef GAME_CTRL_INVULN_EN
        inv_d       = inv_q;
`endif

        if (alive) begin
            if (tick_q == TICK_W'(SCORE_TICK - 1)) begin
                score_d = score_inc(score_q);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            ST_CLEAR: begin
                sweep_go    = 1'b1;
                vga_x_d     = sweep_x;
                vga_y_d     = sweep_y;
                vga_color_d = BG_COLOR;
                vga_write_d = sweep_active;
                if (sweep_done) state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                vga_write_d = 1'b0;
                if (start_rise) begin
                    lives_d = 2'(LIVES);
                    score_d = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (hit_rise) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = ST_OVER;
                    end
`ifdef GAME_CTRL_INVULN_EN
                    else begin
                        state_d = ST_HIT;
                        inv_d   = INV_W'(INVULN_CYCLES - 1);
                    end
`endif
                end
            end
`ifdef GAME_CTRL_INVULN_EN
            ST_HIT: begin
                if (inv_q == '0) state_d = ST_PLAY;
                else             inv_d   = inv_q - INV_W'(1);
            end
`endif
            ST_OVER: begin
                if (start_rise) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= ST_CLEAR;
            start_q      <= 1'b0;
            collision_q  <= 1'b0;
            lives_q      <= '0;
            score_q      <= '0;
            tick_q       <= '0;
            obs_resetn_q <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
            vga_write_q  <= 1'b0;
`ifdef GAME_CTRL_INVULN_EN
            inv_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            collision_q  <= collision;
            lives_q      <= lives_d;
            score_q      <= score_d;
            tick_q       <= tick_d;
            obs_resetn_q <= alive;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_color_q  <= vga_color_d;
            vga_write_q  <= vga_write_d;
`ifdef GAME_CTRL_INVULN_EN
            inv_q        <= inv_d;
`endif
        end
    end

    assign VGA_x      = vga_x_q;
    assign VGA_y      = vga_y_q;
    assign VGA_color  = vga_color_q;
    assign VGA_write  = vga_write_q;
    assign obs_resetn = obs_resetn_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural game model queues expected pixel writes,
// a monitor pops them whenever the DUT asserts VGA_write; status outputs are compared every cycle.
`timescale 1ns/1ps
module tb_game_ctrl;

    localparam int         XS     = 8;
    localparam int         YS     = 4;
    localparam int         NLIVES = 3;
    localparam int         TICK   = 10;
    localparam int         INV    = 20;
    localparam logic [8:0] BG     = 9'h1FF;
`ifdef GAME_CTRL_INVULN_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, collision, obs_write;
    logic [9:0]  obs_x;
    logic [8:0]  obs_y, obs_color;
    logic [9:0]  VGA_x;
    logic [8:0]  VGA_y, VGA_color;
    logic        VGA_write, obs_resetn, game_over;
    logic [1:0]  lives;
    logic [13:0] score;

    always #5 clk = ~clk;

    game_ctrl #(
        .XSCREEN(XS), .YSCREEN(YS), .LIVES(NLIVES),
        .SCORE_TICK(TICK), .INVULN_CYCLES(INV), .BG_COLOR(BG)
    ) dut (
        .Clock(clk), .Resetn(rst_n), .start(start), .collision(collision),
        .obs_x(obs_x), .obs_y(obs_y), .obs_color(obs_color), .obs_write(obs_write),
        .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
        .obs_resetn(obs_resetn), .lives(lives), .score(score), .game_over(game_over)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase, pixel index of the clear, cycles spent alive.
    typedef enum int {M_CLEAR, M_WAIT, M_PLAY, M_INV, M_OVER} mode_t;
    mode_t       m_mode;
    int          m_pix, m_lives, m_alive, m_inv_left;
    bit          m_obs_rst, m_prev_start, m_prev_coll;
    logic [27:0] exp_q[$];

    function automatic int exp_score();
        int v = m_alive / TICK;
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic model_reset();
        m_mode = M_CLEAR; m_pix = 0; m_lives = 0; m_alive = 0; m_inv_left = 0;
        m_obs_rst = 0; m_prev_start = 0; m_prev_coll = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit rs = start && !m_prev_start;
        bit rc = collision && !m_prev_coll;
        bit was_alive = (m_mode == M_PLAY) || (m_mode == M_INV);
        case (m_mode)
            M_CLEAR: begin
                exp_q.push_back({10'(m_pix % XS), 9'(m_pix / XS), BG});
                m_pix++;
                if (m_pix == XS * YS) begin
                    m_pix  = 0;
                    m_mode = M_WAIT;
                end
            end
            M_WAIT: begin
                if (rs) begin
                    m_lives = NLIVES;
                    m_alive = 0;
                    m_mode  = M_PLAY;
                end
            end
            default: begin
                if (obs_write && m_obs_rst) exp_q.push_back({obs_x, obs_y, obs_color});
                if (m_mode == M_PLAY && rc) begin
                    m_lives--;
                    if (m_lives == 0) m_mode = M_OVER;
                    else if (INV_EN) begin
                        m_mode     = M_INV;
                        m_inv_left = INV;
                    end
                end else if (m_mode == M_INV) begin
                    m_inv_left--;
                    if (m_inv_left == 0) m_mode = M_PLAY;
                end else if (m_mode == M_OVER && rs) begin
                    m_mode = M_CLEAR;
                end
            end
        endcase
        if (was_alive) m_alive++;
        m_obs_rst    = was_alive;
        m_prev_start = start;
        m_prev_coll  = collision;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("lives", lives, m_lives);
        check("score", score, exp_score());
        check("game_over", game_over, m_mode == M_OVER);
        check("obs_resetn", obs_resetn, m_obs_rst);
        check("missing_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic rand_obs();
        obs_write = 1'($urandom_range(0, 1));
        obs_x     = 10'($urandom);
        obs_y     = 9'($urandom);
        obs_color = 9'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_obs();
            step();
        end
    endtask

    task automatic pulse_collision();
        collision = 1'b1; rand_obs(); step();
        collision = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; rand_obs(); step();
        start = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_vga", {VGA_x, VGA_y, VGA_color, VGA_write}, 32'd0);
        check("rst_obs_resetn", obs_resetn, 1'b0);
        check("rst_lives", lives, 2'd0);
        check("rst_score", score, 14'd0);
        check("rst_game_over", game_over, 1'b0);
    endtask

    // Monitor: every DUT write must match the oldest queued expectation.
    initial begin
        logic [27:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && VGA_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", VGA_write, 1'b0);
                end else begin
                    exp = exp_q.pop_front();
                    check("pixel", {VGA_x, VGA_y, VGA_color}, exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; collision = 1'b0;
        rand_obs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset_checks();
        rst_n = 1'b1;

        // Clear sweep with start/collision noise that must be ignored.
        for (int i = 0; i < XS * YS; i++) begin
            start     = 1'($urandom_range(0, 1));
            collision = 1'($urandom_range(0, 1));
            rand_obs();
            step();
        end
        start = 1'b0; collision = 1'b0;
        run(3);

        // Game start and score accumulation.
        pulse_start();
        run(100);

        // Directed pass-through.
        obs_write = 1'b1; obs_x = 10'd123; obs_y = 9'd45; obs_color = 9'h1C7;
        step();
        if (m_obs_rst)
            check("passthru", {VGA_x, VGA_y, VGA_color, VGA_write}, {10'd123, 9'd45, 9'h1C7, 1'b1});

        // Hit, ignored hit during invulnerability, hit after the window.
        pulse_collision();
        run(4);
        pulse_collision();
        run(19);
        pulse_collision();
        run(30);
        pulse_collision();
        run(20);

        // Restart from game over, then start held high.
        pulse_start();
        run(XS * YS + 4);
        start = 1'b1;
        run(50);
        start = 1'b0;

        // Randomised play.
        for (int i = 0; i < 600; i++) begin
            collision = ($urandom_range(0, 15) == 0);
            start     = ($urandom_range(0, 31) == 0);
            rand_obs();
            step();
        end
        start = 1'b0; collision = 1'b0;

        // Reset mid-sweep at pixel 17, then a fresh sweep from the origin.
        rst_n = 1'b0; #1;
        model_reset();
        reset_checks();
        @(posedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        run(17);
        rst_n = 1'b0; #1;
        model_reset();
        reset_checks();
        @(posedge clk); @(negedge clk); #1;
        reset_checks();
        rst_n = 1'b1;
        run(XS * YS + 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
